// File: rtl/program_loader.sv
// Serial boot loader: receives a length-prefixed instruction stream and writes it into
// instruction memory, holding the core in reset until a checksum-verified load completes.
//
// state  | meaning
// IDLE   | waiting for start, core held
// LEN_LO | expecting low byte of word count
// LEN_HI | expecting high byte of word count
// DATA   | receiving instruction bytes, writing words
// CHECK  | expecting checksum byte
// DONE   | load verified, core released
// ERROR  | load rejected, core held
module program_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  // Largest legal word count is the full memory depth, so one extra bit is needed.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  logic [2:0]  state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;
  logic [23:0] word_reg;
  logic        accept;

  assign byte_ready = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == DATA)   || (state == CHECK);
  assign busy       = byte_ready;
  assign done       = (state == DONE);
  assign error      = (state == ERROR);
  assign core_hold  = (state != DONE);
  assign accept     = byte_valid && byte_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      word_reg   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state    <= LEN_LO;
            word_idx <= '0;
            byte_cnt <= '0;
            csum     <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_data;
            if ({1'b0, byte_data, len[7:0]} > MAX_WORDS)
              state <= ERROR;
            else if ({byte_data, len[7:0]} == 16'd0)
              state <= CHECK;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_reg[7:0]   <= byte_data;
              2'd1: word_reg[15:8]  <= byte_data;
              2'd2: word_reg[23:16] <= byte_data;
              default: begin
                imem_wdata <= {byte_data, word_reg};
                imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                imem_we    <= 1'b1;
                word_idx   <= word_idx + 16'd1;
                if (word_idx == len - 16'd1)
                  state <= CHECK;
              end
            endcase
          end
        end
        CHECK: begin
          if (accept)
            state <= (byte_data == csum) ? DONE : ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
